// File: rtl/sram_tiled_pkg.sv
// Shared constants and helpers for the tiled 1rw1r SRAM.
// Macro geometry: each macro is MACRO_W bits wide and MACRO_DEPTH words deep.
// rows_f and cols_f give the tiling of a DATA_W x DEPTH memory.
// params_legal_f rejects widths that are not whole bytes and depths that are
// not whole macro rows. The top level turns a failed check into an
// elaboration-time error.
package sram_tiled_pkg;

    localparam int MACRO_W     = 8;
    localparam int MACRO_DEPTH = 1024;
    localparam int MACRO_AW    = 10;

    function automatic int rows_f(input int depth);
        return depth / MACRO_DEPTH;
    endfunction

    function automatic int cols_f(input int data_w);
        return data_w / MACRO_W;
    endfunction

    function automatic bit params_legal_f(input int data_w, input int depth);
        return (data_w > 0) && ((data_w % MACRO_W) == 0) &&
               (depth > 0) && ((depth % MACRO_DEPTH) == 0);
    endfunction

endpackage

// File: rtl/sram_tiled_row.sv
// One row of COLS side-by-side 8x1024 1rw1r macros.
// Each column is a behavioural stand-in for one sky130 macro. Control signals
// are active-low, as on the real cells.
// Ports:
//   clk            macro clock
//   csb0/web0      rw port chip select / write enable (active low, shared by the row)
//   addr0          rw port word address (shared by the row)
//   wmask0         per-column write mask
//   din0/dout0     rw port data; each column owns one byte slice
//   csb1/addr1     read-only port select and address (shared by the row)
//   dout1          read-only port data
// Read data is registered and therefore appears one cycle after the select.
// Data registers hold their value while the port is deselected.
module sram_tiled_row
    import sram_tiled_pkg::*;
#(
    parameter int COLS = 2
) (
    input  logic                     clk,
    input  logic                     csb0,
    input  logic                     web0,
    input  logic [MACRO_AW-1:0]      addr0,
    input  logic [COLS-1:0]          wmask0,
    input  logic [COLS*MACRO_W-1:0]  din0,
    output logic [COLS*MACRO_W-1:0]  dout0,
    input  logic                     csb1,
    input  logic [MACRO_AW-1:0]      addr1,
    output logic [COLS*MACRO_W-1:0]  dout1
);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [MACRO_W-1:0] mem [MACRO_DEPTH];
        logic [MACRO_W-1:0] q0;
        logic [MACRO_W-1:0] q1;

        always_ff @(posedge clk) begin
            if (!csb0 && !web0 && wmask0[c]) begin
                mem[addr0] <= din0[c*MACRO_W +: MACRO_W];
            end
            if (!csb0 && web0) begin
                q0 <= mem[addr0];
            end
            if (!csb1) begin
                q1 <= mem[addr1];
            end
        end

        assign dout0[c*MACRO_W +: MACRO_W] = q0;
        assign dout1[c*MACRO_W +: MACRO_W] = q1;
    end

endmodule

// File: rtl/sram_tiled_1rw1r.sv
// DATA_W x DEPTH memory with one read/write port and one read-only port.
// The memory is built from 8x1024 1rw1r macro tiles: byte columns across the
// width and 1024-word rows down the depth.
// Optional build macro: SRAM_COLLISION_FWD_EN. When it is defined, a read that
// collides with a same-address write returns the written bytes.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   r_addr, r_valid                read-port request
//   r_data_out, r_data_valid       read-port response (one cycle later)
//   r_oor                          responding read was out of range
//   rw_addr, rw_data_in, rw_w_en   rw-port request (w_en=1 write, 0 read)
//   rw_byte_en, rw_valid           per-byte write enable, request strobe
//   rw_data_out, rw_data_valid     rw-port read response (reads only)
//   rw_oor                         responding rw read was out of range
//   collision                      responding read overlapped a same-address write
// Handshake: a request is accepted in every cycle its valid is high; there is
// no back-pressure. Each read produces exactly one response, marked by its
// *_data_valid in the following cycle. Writes produce no response. Data outputs
// are 0 whenever their valid is low or the response is out of range.
module sram_tiled_1rw1r
    import sram_tiled_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  DEPTH  = 2048,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       r_addr,
    input  logic                r_valid,
    output logic [DATA_W-1:0]   r_data_out,
    output logic                r_data_valid,
    output logic                r_oor,
    input  logic [AW-1:0]       rw_addr,
    input  logic [DATA_W-1:0]   rw_data_in,
    input  logic                rw_w_en,
    input  logic [DATA_W/8-1:0] rw_byte_en,
    input  logic                rw_valid,
    output logic [DATA_W-1:0]   rw_data_out,
    output logic                rw_data_valid,
    output logic                rw_oor,
    output logic                collision
);

    localparam int ROWS = rows_f(DEPTH);
    localparam int COLS = cols_f(DATA_W);
    localparam int RSW  = (ROWS > 1) ? $clog2(ROWS) : 1;

    if (!params_legal_f(DATA_W, DEPTH)) begin : g_bad_params
        $error("sram_tiled_1rw1r: DATA_W must be a multiple of 8 and DEPTH a multiple of 1024");
    end

    // Row index over the full address width so that a non-power-of-two row
    // count can be range-checked. Rows at or above ROWS are out of range.
    logic [AW-1:0]  r_row_full, rw_row_full;
    logic           r_in_range, rw_in_range;
    logic [RSW-1:0] r_row, rw_row;

    assign r_row_full  = r_addr  >> MACRO_AW;
    assign rw_row_full = rw_addr >> MACRO_AW;
    assign r_in_range  = r_row_full  < AW'(ROWS);
    assign rw_in_range = rw_row_full < AW'(ROWS);
    assign r_row       = r_row_full[RSW-1:0];
    assign rw_row      = rw_row_full[RSW-1:0];

    logic [DATA_W-1:0] r_dout  [ROWS];
    logic [DATA_W-1:0] rw_dout [ROWS];

    for (genvar g = 0; g < ROWS; g++) begin : g_row
        logic csb0, csb1;
        assign csb0 = ~(rw_valid & rw_in_range & (rw_row == RSW'(g)));
        assign csb1 = ~(r_valid  & r_in_range  & (r_row  == RSW'(g)));

        sram_tiled_row #(.COLS(COLS)) u_row (
            .clk    (clk),
            .csb0   (csb0),
            .web0   (~rw_w_en),
            .addr0  (rw_addr[MACRO_AW-1:0]),
            .wmask0 (rw_byte_en),
            .din0   (rw_data_in),
            .dout0  (rw_dout[g]),
            .csb1   (csb1),
            .addr1  (r_addr[MACRO_AW-1:0]),
            .dout1  (r_dout[g])
        );
    end

    // A zero byte enable writes nothing, so it cannot collide.
    logic coll_d;
    assign coll_d = rw_valid & rw_w_en & r_valid & (r_addr == rw_addr) &
                    r_in_range & rw_in_range & (|rw_byte_en);

    logic           r_vld_q, r_oor_q, rw_vld_q, rw_oor_q, coll_q;
    logic [RSW-1:0] r_row_q, rw_row_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_q  <= 1'b0;
            r_oor_q  <= 1'b0;
            r_row_q  <= '0;
            rw_vld_q <= 1'b0;
            rw_oor_q <= 1'b0;
            rw_row_q <= '0;
            coll_q   <= 1'b0;
        end else begin
            r_vld_q  <= r_valid;
            r_oor_q  <= r_valid & ~r_in_range;
            r_row_q  <= r_row;
            rw_vld_q <= rw_valid & ~rw_w_en;
            rw_oor_q <= rw_valid & ~rw_w_en & ~rw_in_range;
            rw_row_q <= rw_row;
            coll_q   <= coll_d;
        end
    end

    // Pick the macro row that was selected when the request was accepted.
    logic [DATA_W-1:0] r_raw, rw_raw, r_merged;

    always_comb begin
        r_raw  = '0;
        rw_raw = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (r_row_q == RSW'(i)) begin
                r_raw = r_dout[i];
            end
            if (rw_row_q == RSW'(i)) begin
                rw_raw = rw_dout[i];
            end
        end
    end

`ifdef SRAM_COLLISION_FWD_EN
    // The write data and mask are captured alongside the collision so that the
    // colliding read returns the written bytes instead of the macro's
    // undefined same-cycle output.
    logic [DATA_W-1:0] fwd_data_q;
    logic [COLS-1:0]   fwd_be_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_data_q <= '0;
            fwd_be_q   <= '0;
        end else if (coll_d) begin
            fwd_data_q <= rw_data_in;
            fwd_be_q   <= rw_byte_en;
        end
    end

    always_comb begin
        r_merged = r_raw;
        for (int c = 0; c < COLS; c++) begin
            if (coll_q && fwd_be_q[c]) begin
                r_merged[c*MACRO_W +: MACRO_W] = fwd_data_q[c*MACRO_W +: MACRO_W];
            end
        end
    end
`else
    assign r_merged = r_raw;
`endif

    assign r_data_valid  = r_vld_q;
    assign r_oor         = r_oor_q;
    assign r_data_out    = (r_vld_q && !r_oor_q) ? r_merged : '0;
    assign rw_data_valid = rw_vld_q;
    assign rw_oor        = rw_oor_q;
    assign rw_data_out   = (rw_vld_q && !rw_oor_q) ? rw_raw : '0;
    assign collision     = coll_q;

endmodule

// File: tb/tb_sram_tiled_1rw1r.sv
// Bench for sram_tiled_1rw1r. It uses three instances:
//   u_dut   16 x 2048  table-driven vectors plus an r-port scoreboard, then a reset sequence
//   u_dut3  16 x 3072  out-of-range handling (AW = 12, row 3 is out of range)
//   u_dut32 32 x 1024  byte-enable merge on a wide word
module tb_sram_tiled_1rw1r;

`ifdef SRAM_COLLISION_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- u_dut: 16 x 2048 ----------------
    logic [10:0] a_r_addr = '0, a_rw_addr = '0;
    logic        a_r_valid = 0, a_rw_valid = 0, a_rw_w_en = 0;
    logic [15:0] a_rw_data_in = '0;
    logic [1:0]  a_rw_byte_en = '0;
    logic [15:0] a_r_data_out, a_rw_data_out;
    logic        a_r_data_valid, a_r_oor, a_rw_data_valid, a_rw_oor, a_collision;

    sram_tiled_1rw1r #(.DATA_W(16), .DEPTH(2048)) u_dut (
        .clk(clk), .rst(rst),
        .r_addr(a_r_addr), .r_valid(a_r_valid),
        .r_data_out(a_r_data_out), .r_data_valid(a_r_data_valid), .r_oor(a_r_oor),
        .rw_addr(a_rw_addr), .rw_data_in(a_rw_data_in), .rw_w_en(a_rw_w_en),
        .rw_byte_en(a_rw_byte_en), .rw_valid(a_rw_valid),
        .rw_data_out(a_rw_data_out), .rw_data_valid(a_rw_data_valid), .rw_oor(a_rw_oor),
        .collision(a_collision)
    );

    // ---------------- u_dut3: 16 x 3072 ----------------
    logic [11:0] b_r_addr = '0, b_rw_addr = '0;
    logic        b_r_valid = 0, b_rw_valid = 0, b_rw_w_en = 0;
    logic [15:0] b_rw_data_in = '0;
    logic [1:0]  b_rw_byte_en = '0;
    logic [15:0] b_r_data_out, b_rw_data_out;
    logic        b_r_data_valid, b_r_oor, b_rw_data_valid, b_rw_oor, b_collision;

    sram_tiled_1rw1r #(.DATA_W(16), .DEPTH(3072)) u_dut3 (
        .clk(clk), .rst(rst),
        .r_addr(b_r_addr), .r_valid(b_r_valid),
        .r_data_out(b_r_data_out), .r_data_valid(b_r_data_valid), .r_oor(b_r_oor),
        .rw_addr(b_rw_addr), .rw_data_in(b_rw_data_in), .rw_w_en(b_rw_w_en),
        .rw_byte_en(b_rw_byte_en), .rw_valid(b_rw_valid),
        .rw_data_out(b_rw_data_out), .rw_data_valid(b_rw_data_valid), .rw_oor(b_rw_oor),
        .collision(b_collision)
    );

    // ---------------- u_dut32: 32 x 1024 ----------------
    logic [9:0]  c_r_addr = '0, c_rw_addr = '0;
    logic        c_r_valid = 0, c_rw_valid = 0, c_rw_w_en = 0;
    logic [31:0] c_rw_data_in = '0;
    logic [3:0]  c_rw_byte_en = '0;
    logic [31:0] c_r_data_out, c_rw_data_out;
    logic        c_r_data_valid, c_r_oor, c_rw_data_valid, c_rw_oor, c_collision;

    sram_tiled_1rw1r #(.DATA_W(32), .DEPTH(1024)) u_dut32 (
        .clk(clk), .rst(rst),
        .r_addr(c_r_addr), .r_valid(c_r_valid),
        .r_data_out(c_r_data_out), .r_data_valid(c_r_data_valid), .r_oor(c_r_oor),
        .rw_addr(c_rw_addr), .rw_data_in(c_rw_data_in), .rw_w_en(c_rw_w_en),
        .rw_byte_en(c_rw_byte_en), .rw_valid(c_rw_valid),
        .rw_data_out(c_rw_data_out), .rw_data_valid(c_rw_data_valid), .rw_oor(c_rw_oor),
        .collision(c_collision)
    );

    // ---------------- vector table for u_dut ----------------
    // Expected fields describe the outputs seen just after this vector's clock edge.
    typedef struct {
        logic        r_v;
        logic [10:0] r_a;
        logic        rw_v;
        logic        rw_we;
        logic [10:0] rw_a;
        logic [15:0] rw_d;
        logic [1:0]  be;
        logic        e_rv;
        logic        chk_r;
        logic [15:0] e_rd;
        logic        e_rwv;
        logic [15:0] e_rwd;
        logic        e_coll;
    } vec_t;

    vec_t vecs[$];

    // r-port scoreboard: {check_data, expected_data}
    logic [16:0] exp_q[$];

    function automatic vec_t mk(input logic r_v, input logic [10:0] r_a,
                                input logic rw_v, input logic rw_we, input logic [10:0] rw_a,
                                input logic [15:0] rw_d, input logic [1:0] be,
                                input logic chk_r, input logic [15:0] e_rd,
                                input logic [15:0] e_rwd, input logic e_coll);
        vec_t v;
        v.r_v = r_v; v.r_a = r_a; v.rw_v = rw_v; v.rw_we = rw_we; v.rw_a = rw_a;
        v.rw_d = rw_d; v.be = be;
        v.e_rv = r_v; v.chk_r = chk_r; v.e_rd = e_rd;
        v.e_rwv = rw_v & ~rw_we; v.e_rwd = e_rwd; v.e_coll = e_coll;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        logic [16:0] e;
        a_r_valid    = v.r_v;
        a_r_addr     = v.r_a;
        a_rw_valid   = v.rw_v;
        a_rw_w_en    = v.rw_we;
        a_rw_addr    = v.rw_a;
        a_rw_data_in = v.rw_d;
        a_rw_byte_en = v.be;
        if (v.r_v) exp_q.push_back({v.chk_r, v.e_rd});
        tick();
        check($sformatf("v%0d_r_valid", idx), a_r_data_valid, v.e_rv);
        check($sformatf("v%0d_rw_valid", idx), a_rw_data_valid, v.e_rwv);
        check($sformatf("v%0d_rw_data", idx), a_rw_data_out, v.e_rwd);
        check($sformatf("v%0d_collision", idx), a_collision, v.e_coll);
        check($sformatf("v%0d_r_oor", idx), a_r_oor, 0);
        check($sformatf("v%0d_rw_oor", idx), a_rw_oor, 0);
        if (a_r_data_valid) begin
            if (exp_q.size() == 0) begin
                check($sformatf("v%0d_r_spurious", idx), a_r_data_valid, 0);
            end else begin
                e = exp_q.pop_front();
                if (e[16]) check($sformatf("v%0d_r_data", idx), a_r_data_out, e[15:0]);
            end
        end else begin
            check($sformatf("v%0d_r_data_idle", idx), a_r_data_out, 0);
        end
    endtask

    task automatic b_op(input logic rv, input logic [11:0] ra, input logic rwv, input logic we,
                        input logic [11:0] rwa, input logic [15:0] d, input logic [1:0] be);
        b_r_valid = rv; b_r_addr = ra;
        b_rw_valid = rwv; b_rw_w_en = we; b_rw_addr = rwa; b_rw_data_in = d; b_rw_byte_en = be;
        tick();
    endtask

    task automatic c_op(input logic rv, input logic [9:0] ra, input logic rwv, input logic we,
                        input logic [9:0] rwa, input logic [31:0] d, input logic [3:0] be);
        c_r_valid = rv; c_r_addr = ra;
        c_rw_valid = rwv; c_rw_w_en = we; c_rw_addr = rwa; c_rw_data_in = d; c_rw_byte_en = be;
        tick();
    endtask

    initial begin
        // ------------- reset state -------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_r_valid", a_r_data_valid, 0);
        check("rst_a_rw_valid", a_rw_data_valid, 0);
        check("rst_a_collision", a_collision, 0);
        check("rst_a_r_oor", a_r_oor, 0);
        check("rst_a_rw_oor", a_rw_oor, 0);
        check("rst_a_r_data", a_r_data_out, 0);
        check("rst_a_rw_data", a_rw_data_out, 0);
        check("rst_b_r_valid", b_r_data_valid, 0);
        check("rst_c_rw_valid", c_rw_data_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ------------- table for u_dut -------------
        //               r_v  r_a     rw_v we  rw_a    rw_d      be     chk_r  e_rd      e_rwd     coll
        vecs.push_back(mk(0, 11'h000, 1, 1, 11'h005, 16'hBEEF, 2'b11, 1'b1, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 11'h000, 1, 1, 11'h405, 16'h1234, 2'b11, 1'b1, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(1, 11'h005, 0, 0, 11'h000, 16'h0000, 2'b00, 1'b1, 16'hBEEF, 16'h0000, 0));
        vecs.push_back(mk(1, 11'h405, 0, 0, 11'h000, 16'h0000, 2'b00, 1'b1, 16'h1234, 16'h0000, 0));
        vecs.push_back(mk(0, 11'h000, 1, 1, 11'h010, 16'hAAAA, 2'b11, 1'b1, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 11'h000, 1, 1, 11'h010, 16'h5555, 2'b01, 1'b1, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 11'h000, 1, 0, 11'h010, 16'h0000, 2'b00, 1'b1, 16'h0000, 16'hAA55, 0));
        vecs.push_back(mk(0, 11'h000, 1, 1, 11'h020, 16'h1111, 2'b11, 1'b1, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(1, 11'h020, 1, 1, 11'h020, 16'h2222, 2'b11, FWD,  16'h2222, 16'h0000, 1));
        vecs.push_back(mk(1, 11'h020, 1, 1, 11'h030, 16'h3333, 2'b11, 1'b1, 16'h2222, 16'h0000, 0));
        vecs.push_back(mk(1, 11'h030, 1, 0, 11'h005, 16'h0000, 2'b00, 1'b1, 16'h3333, 16'hBEEF, 0));
        vecs.push_back(mk(1, 11'h005, 1, 1, 11'h005, 16'hFFFF, 2'b00, 1'b1, 16'hBEEF, 16'h0000, 0));
        vecs.push_back(mk(1, 11'h030, 1, 1, 11'h030, 16'h9999, 2'b10, FWD,  16'h9933, 16'h0000, 1));
        vecs.push_back(mk(1, 11'h030, 0, 0, 11'h000, 16'h0000, 2'b00, 1'b1, 16'h9933, 16'h0000, 0));
        vecs.push_back(mk(0, 11'h000, 1, 1, 11'h7FF, 16'hCAFE, 2'b11, 1'b1, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(1, 11'h7FF, 1, 0, 11'h7FF, 16'h0000, 2'b00, 1'b1, 16'hCAFE, 16'hCAFE, 0));
        vecs.push_back(mk(0, 11'h000, 0, 0, 11'h000, 16'h0000, 2'b00, 1'b1, 16'h0000, 16'h0000, 0));
        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
        check("r_queue_drained", exp_q.size(), 0);

        // ------------- u_dut3: out-of-range -------------
        b_op(0, 12'h000, 1, 1, 12'h000, 16'h0123, 2'b11);
        b_op(1, 12'hC00, 1, 1, 12'hC00, 16'hFFFF, 2'b11);
        check("oor_r_valid", b_r_data_valid, 1);
        check("oor_r_flag", b_r_oor, 1);
        check("oor_r_data", b_r_data_out, 0);
        check("oor_no_collision", b_collision, 0);
        b_op(1, 12'h000, 1, 0, 12'hC00, 16'h0000, 2'b00);
        check("oor_rw_valid", b_rw_data_valid, 1);
        check("oor_rw_flag", b_rw_oor, 1);
        check("oor_rw_data", b_rw_data_out, 0);
        check("oor_row0_unchanged", b_r_data_out, 16'h0123);
        check("oor_row0_flag", b_r_oor, 0);
        b_op(0, 12'h000, 1, 1, 12'h800, 16'h5A5A, 2'b11);
        b_op(1, 12'h800, 1, 0, 12'hFFF, 16'h0000, 2'b00);
        check("row2_r_data", b_r_data_out, 16'h5A5A);
        check("row2_r_oor", b_r_oor, 0);
        check("oor_top_rw_flag", b_rw_oor, 1);
        check("oor_top_rw_data", b_rw_data_out, 0);
        b_op(0, 12'h000, 0, 0, 12'h000, 16'h0000, 2'b00);
        check("oor_idle_r_flag", b_r_oor, 0);
        check("oor_idle_rw_flag", b_rw_oor, 0);

        // ------------- u_dut32: wide byte enables -------------
        c_op(0, 10'h000, 1, 1, 10'h003, 32'h0000_0000, 4'b1111);
        c_op(0, 10'h000, 1, 1, 10'h003, 32'hDEAD_BEEF, 4'b1010);
        c_op(1, 10'h003, 1, 0, 10'h003, 32'h0000_0000, 4'b0000);
        check("w32_rw_data", c_rw_data_out, 32'hDE00_BE00);
        check("w32_r_data", c_r_data_out, 32'hDE00_BE00);
        check("w32_rw_valid", c_rw_data_valid, 1);
        c_op(0, 10'h000, 0, 0, 10'h000, 32'h0, 4'b0000);

        // ------------- u_dut: reset mid-stream -------------
        for (int i = 0; i < 8; i++) begin
            a_r_valid = 1; a_r_addr = 11'h005;
            a_rw_valid = 1; a_rw_w_en = 0; a_rw_addr = 11'h405; a_rw_byte_en = 2'b00;
            if (i == 4) begin
                rst = 1'b1;
                #1;
                check("rst_async_r_valid", a_r_data_valid, 0);
                check("rst_async_rw_valid", a_rw_data_valid, 0);
                check("rst_async_r_data", a_r_data_out, 0);
            end
            if (i == 6) rst = 1'b0;
            tick();
            if (i == 4 || i == 5) begin
                check($sformatf("rst_c%0d_r_valid", i), a_r_data_valid, 0);
                check($sformatf("rst_c%0d_rw_valid", i), a_rw_data_valid, 0);
            end else begin
                check($sformatf("rst_c%0d_r_valid", i), a_r_data_valid, 1);
                check($sformatf("rst_c%0d_r_data", i), a_r_data_out, 16'hBEEF);
                check($sformatf("rst_c%0d_rw_valid", i), a_rw_data_valid, 1);
                check($sformatf("rst_c%0d_rw_data", i), a_rw_data_out, 16'h1234);
            end
        end
        a_r_valid = 0; a_rw_valid = 0;
        tick();
        check("final_idle_r_valid", a_r_data_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
